// File: rtl/axis_width_split.sv
// rtl/axis_width_split.sv - splits wide AXI-Stream beats into MSB-first slim beats
module axis_width_split #(
    parameter int WIDE_DSIZE = 64,
    parameter int SLIM_DSIZE = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [WIDE_DSIZE-1:0]     wide_tdata,
    input  logic [WIDE_DSIZE/8-1:0]   wide_tkeep,
    input  logic                      wide_tvalid,
    input  logic                      wide_tlast,
    output logic                      wide_tready,
    output logic [SLIM_DSIZE-1:0]     slim_tdata,
    output logic [SLIM_DSIZE/8-1:0]   slim_tkeep,
    output logic                      slim_tvalid,
    output logic                      slim_tlast,
    input  logic                      slim_tready
);
    localparam int NSIZE  = WIDE_DSIZE / SLIM_DSIZE;
    localparam int WKSIZE = WIDE_DSIZE / 8;
    localparam int SKSIZE = SLIM_DSIZE / 8;
    localparam int PW     = (NSIZE > 1) ? $clog2(NSIZE) : 1;

    if ((WIDE_DSIZE % SLIM_DSIZE) != 0 || (SLIM_DSIZE % 8) != 0 || NSIZE < 2) begin : g_param_check
        $error("axis_width_split: WIDE_DSIZE must be a multiple of SLIM_DSIZE, SLIM_DSIZE a multiple of 8, ratio >= 2");
    end

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t                state, state_d;
    logic [PW-1:0]         point, point_d;
    logic [PW-1:0]         final_q, final_d;
    logic [WIDE_DSIZE-1:0] data_q;
    logic [WKSIZE-1:0]     keep_q;
    logic                  last_q;
    logic                  load;
    logic                  at_final;
    logic [WIDE_DSIZE-1:0] data_sh;
    logic [WKSIZE-1:0]     keep_sh;

    // Last beat stops at the highest slice carrying any byte; an all-empty last beat still emits slice 0 for tlast.
    always_comb begin
        final_d = PW'(NSIZE - 1);
        if (wide_tlast) begin
            final_d = '0;
            for (int i = 0; i < NSIZE; i++) begin
                if (wide_tkeep[WKSIZE-1-i*SKSIZE -: SKSIZE] != '0) final_d = PW'(i);
            end
        end
    end

    assign at_final    = (point == final_q);
    assign slim_tvalid = (state == SHIFT);
    assign slim_tlast  = slim_tvalid && last_q && at_final;
    assign wide_tready = !areset && ((state == EMPTY) || (slim_tvalid && slim_tready && at_final));

    assign data_sh    = data_q << (point * SLIM_DSIZE);
    assign keep_sh    = keep_q << (point * SKSIZE);
    assign slim_tdata = data_sh[WIDE_DSIZE-1 -: SLIM_DSIZE];
    assign slim_tkeep = keep_sh[WKSIZE-1 -: SKSIZE];

    always_comb begin
        state_d = state;
        point_d = point;
        load    = 1'b0;
        case (state)
            EMPTY: begin
                if (wide_tvalid) begin
                    load    = 1'b1;
                    point_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (slim_tready) begin
                    if (!at_final) begin
                        point_d = point + 1'b1;
                    end else if (wide_tvalid) begin
                        load    = 1'b1;
                        point_d = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= EMPTY;
            point   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            final_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state <= state_d;
            point <= point_d;
            if (load) begin
                data_q  <= wide_tdata;
                keep_q  <= wide_tkeep;
                final_q <= final_d;
                last_q  <= wide_tlast;
            end
        end
    end
endmodule

// File: tb/tb_axis_width_split.sv
// tb/tb_axis_width_split.sv - directed and randomized checks of axis_width_split
module tb_axis_width_split;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;

    logic [63:0] a_wdata = '0;
    logic [7:0]  a_wkeep = '0;
    logic        a_wvalid = 1'b0, a_wlast = 1'b0, a_wready;
    logic [7:0]  a_sdata;
    logic [0:0]  a_skeep;
    logic        a_svalid, a_slast, a_srdy = 1'b0;

    logic [31:0] b_wdata = '0;
    logic [3:0]  b_wkeep = '0;
    logic        b_wvalid = 1'b0, b_wlast = 1'b0, b_wready;
    logic [15:0] b_sdata;
    logic [1:0]  b_skeep;
    logic        b_svalid, b_slast, b_srdy = 1'b0;

    int total = 0;
    int bad = 0;
    int wready_low = 0;
    int ncyc;

    logic [63:0] wq_d[$];
    logic [7:0]  wq_k[$];
    logic        wq_l[$];
    logic [7:0]  ed[$];
    logic        ek[$];
    logic        el[$];

    logic        stall_prev = 1'b0;
    logic [7:0]  stall_d;
    logic        stall_k, stall_l;

    always #5 aclk = ~aclk;

    axis_width_split #(.WIDE_DSIZE(64), .SLIM_DSIZE(8)) dut_a (
        .aclk(aclk), .areset(areset),
        .wide_tdata(a_wdata), .wide_tkeep(a_wkeep), .wide_tvalid(a_wvalid),
        .wide_tlast(a_wlast), .wide_tready(a_wready),
        .slim_tdata(a_sdata), .slim_tkeep(a_skeep), .slim_tvalid(a_svalid),
        .slim_tlast(a_slast), .slim_tready(a_srdy)
    );

    axis_width_split #(.WIDE_DSIZE(32), .SLIM_DSIZE(16)) dut_b (
        .aclk(aclk), .areset(areset),
        .wide_tdata(b_wdata), .wide_tkeep(b_wkeep), .wide_tvalid(b_wvalid),
        .wide_tlast(b_wlast), .wide_tready(b_wready),
        .slim_tdata(b_sdata), .slim_tkeep(b_skeep), .slim_tvalid(b_svalid),
        .slim_tlast(b_slast), .slim_tready(b_srdy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every slice of a non-last beat, last beat trimmed after its highest non-empty slice.
    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        wq_d.push_back(d);
        wq_k.push_back(k);
        wq_l.push_back(l);
        n = 8;
        if (l) begin
            n = 1;
            for (int i = 0; i < 8; i++) if (k[7-i]) n = i + 1;
        end
        for (int i = 0; i < n; i++) begin
            ed.push_back(d[63-8*i -: 8]);
            ek.push_back(k[7-i]);
            el.push_back(l && (i == n - 1));
        end
    endtask

    task automatic step_a(input logic rdy);
        @(negedge aclk);
        a_wvalid = (wq_d.size() != 0);
        if (a_wvalid) begin
            a_wdata = wq_d[0];
            a_wkeep = wq_k[0];
            a_wlast = wq_l[0];
        end
        a_srdy = rdy;
        #1;
        if (stall_prev) begin
            check("stall_valid", a_svalid, 1'b1);
            check("stall_data", a_sdata, stall_d);
            check("stall_keep", a_skeep, stall_k);
            check("stall_last", a_slast, stall_l);
        end
        stall_prev = a_svalid && !a_srdy;
        stall_d = a_sdata;
        stall_k = a_skeep[0];
        stall_l = a_slast;
        if (!a_wready) wready_low++;
        if (a_wvalid && a_wready) begin
            void'(wq_d.pop_front());
            void'(wq_k.pop_front());
            void'(wq_l.pop_front());
        end
        if (a_svalid && a_srdy) begin
            if (ed.size() == 0) begin
                check("spurious_beat", a_svalid, 1'b0);
            end else begin
                check("slim_data", a_sdata, ed.pop_front());
                check("slim_keep", a_skeep, ek.pop_front());
                check("slim_last", a_slast, el.pop_front());
            end
        end
    endtask

    task automatic run_a(input logic rand_rdy, input int limit, output int n);
        n = 0;
        while (ed.size() > 0 && n < limit) begin
            step_a(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check("drain", ed.size(), 0);
    endtask

    initial begin
        // reset state
        #2;
        check("rst_svalid", a_svalid, 1'b0);
        check("rst_slast", a_slast, 1'b0);
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("rst_wready", a_wready, 1'b1);
        check("rst_svalid2", a_svalid, 1'b0);
        check("rst_sdata", a_sdata, 8'h00);
        check("rst_skeep", a_skeep, 1'b0);
        check("rst_slast2", a_slast, 1'b0);

        // three back-to-back full beats, no gaps
        push_beat(64'h0011223344556677, 8'hFF, 1'b0);
        push_beat(64'h8899AABBCCDDEEFF, 8'hFF, 1'b0);
        push_beat(64'h0102030405060708, 8'hFF, 1'b1);
        wready_low = 0;
        run_a(1'b0, 100, ncyc);
        check("t1_cycles", ncyc, 25);
        check("t1_wready_low", wready_low, 21);

        // trimmed last beat, then back to EMPTY
        push_beat(64'hDEADBEEF_00000000, 8'hF0, 1'b1);
        run_a(1'b0, 100, ncyc);
        check("t2_cycles", ncyc, 5);
        step_a(1'b1);
        check("t2_wready_idle", a_wready, 1'b1);
        check("t2_svalid_idle", a_svalid, 1'b0);

        // empty last beat keeps tlast; partial non-last beat is not trimmed
        push_beat(64'h7766554433221100, 8'h00, 1'b1);
        push_beat(64'h0123456789ABCDEF, 8'h0F, 1'b0);
        run_a(1'b0, 100, ncyc);
        check("t3_cycles", ncyc, 10);

        // random packets with random back-pressure
        for (int p = 0; p < 200; p++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                logic [63:0] d;
                d = {$urandom, $urandom};
                if (b == nb - 1) push_beat(d, 8'($urandom), 1'b1);
                else push_beat(d, 8'hFF, 1'b0);
            end
        end
        run_a(1'b1, 40000, ncyc);
        check("t4_wq_empty", wq_d.size(), 0);

        // reset during slice 3
        stall_prev = 1'b0;
        @(negedge aclk);
        a_srdy = 1'b1;
        a_wvalid = 1'b1;
        a_wdata = 64'h1011121314151617;
        a_wkeep = 8'hFF;
        a_wlast = 1'b0;
        @(negedge aclk);
        a_wvalid = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check("t5_slice3", a_sdata, 8'h13);
        areset = 1'b1;
        #1;
        check("t5_async_svalid", a_svalid, 1'b0);
        check("t5_async_slast", a_slast, 1'b0);
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        check("t5_wready", a_wready, 1'b1);
        check("t5_svalid", a_svalid, 1'b0);
        push_beat({8{8'hA5}}, 8'hFF, 1'b1);
        run_a(1'b0, 100, ncyc);
        check("t5_cycles", ncyc, 9);

        // 32 -> 16 instance
        @(negedge aclk);
        b_srdy = 1'b1;
        b_wvalid = 1'b1;
        b_wdata = 32'h12345678;
        b_wkeep = 4'hF;
        b_wlast = 1'b0;
        #1;
        check("t6_wready0", b_wready, 1'b1);
        @(negedge aclk);
        b_wdata = 32'h9ABC0000;
        b_wkeep = 4'hC;
        b_wlast = 1'b1;
        #1;
        check("t6_d0", b_sdata, 16'h1234);
        check("t6_k0", b_skeep, 2'h3);
        check("t6_l0", b_slast, 1'b0);
        check("t6_wready_busy", b_wready, 1'b0);
        @(negedge aclk);
        #1;
        check("t6_d1", b_sdata, 16'h5678);
        check("t6_l1", b_slast, 1'b0);
        check("t6_wready_final", b_wready, 1'b1);
        @(negedge aclk);
        b_wvalid = 1'b0;
        #1;
        check("t6_d2", b_sdata, 16'h9ABC);
        check("t6_k2", b_skeep, 2'h3);
        check("t6_l2", b_slast, 1'b1);
        @(negedge aclk);
        #1;
        check("t6_idle", b_svalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
